// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter.
package vram_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 15;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned STARVE_LIMIT_DEF = 8;

   typedef enum logic [1:0] {IDLE, ACK, RECOVER} cpu_state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_CPU} grant_t;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous-read VRAM between display scanout
// (fixed priority) and a CPU bus slave, with a starvation guard for the CPU.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  cpu_sel_i,
   input  logic                  cpu_wr_en_i,
   input  logic [DATA_W/8-1:0]   cpu_wr_mask_i,
   input  logic [ADDR_W-1:0]     cpu_address_in_i,
   input  logic [DATA_W-1:0]     cpu_data_in_i,
   output logic [DATA_W-1:0]     cpu_data_out_o,
   output logic                  cpu_ack_o,
   input  logic                  disp_req_i,
   input  logic [ADDR_W-1:0]     disp_addr_i,
   output logic                  disp_gnt_o,
   output logic                  disp_rvalid_o,
   output logic [DATA_W-1:0]     disp_rdata_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic                  mem_wr_en_o,
   output logic [DATA_W/8-1:0]   mem_wr_mask_o,
   output logic [DATA_W-1:0]     mem_data_o,
   input  logic [DATA_W-1:0]     mem_data_i
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   cpu_state_t          r_state;
   logic [CNT_W-1:0]    r_starve;
   logic                r_ack_wr;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_cpu_hold;
   logic [DATA_W-1:0]   r_disp_hold;

   grant_t              w_grant;
   logic                w_cpu_elig;
   logic                w_force;

   // Grant decision; reset masks every grant so no write can slip through.
   always_comb begin
      w_cpu_elig = (r_state == IDLE) && cpu_sel_i;
      w_force    = w_cpu_elig && (r_starve == CNT_W'(STARVE_LIMIT));
      w_grant    = GNT_NONE;
      if (!reset_i) begin
         if (disp_req_i && !w_force) begin
            w_grant = GNT_DISP;
         end else if (w_cpu_elig) begin
            w_grant = GNT_CPU;
         end
      end
   end

   // Memory port follows the grant; idle cycles prefetch the display address.
   always_comb begin
      mem_addr_o    = disp_addr_i;
      mem_wr_en_o   = 1'b0;
      mem_wr_mask_o = '0;
      mem_data_o    = cpu_data_in_i;
      if (w_grant == GNT_CPU) begin
         mem_addr_o    = cpu_address_in_i;
         mem_wr_en_o   = cpu_wr_en_i;
         mem_wr_mask_o = cpu_wr_mask_i;
      end
   end

   assign disp_gnt_o = (w_grant == GNT_DISP);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= IDLE;
         r_starve    <= '0;
         r_ack_wr    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_cpu_hold  <= '0;
         r_disp_hold <= '0;
      end else begin
         r_rvalid <= (w_grant == GNT_DISP);
         if (r_rvalid) begin
            r_disp_hold <= mem_data_i;
         end
         if ((r_state == ACK) && !r_ack_wr) begin
            r_cpu_hold <= mem_data_i;
         end

         case (r_state)
            IDLE: begin
               if (w_grant == GNT_CPU) begin
                  r_state  <= ACK;
                  r_ack_wr <= cpu_wr_en_i;
               end
            end
            ACK:     r_state <= RECOVER;
            RECOVER: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (w_grant == GNT_CPU) begin
            r_starve <= '0;
         end else if (w_cpu_elig) begin
            if (r_starve != CNT_W'(STARVE_LIMIT)) begin
               r_starve <= r_starve + CNT_W'(1);
            end
         end else begin
            r_starve <= '0;
         end
      end
   end

   // The BRAM output register supplies data in the response cycle; the hold
   // registers keep the read buses stable outside of it (and across write acks).
   assign cpu_ack_o      = (r_state == ACK);
   assign cpu_data_out_o = ((r_state == ACK) && !r_ack_wr) ? mem_data_i : r_cpu_hold;
   assign disp_rvalid_o  = r_rvalid;
   assign disp_rdata_o   = r_rvalid ? mem_data_i : r_disp_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic, checked against a cycle-level behavioural model and a shadow memory.
module tb_vram_arbiter;

   localparam int unsigned AW  = 15;
   localparam int unsigned DW  = 32;
   localparam int unsigned MW  = DW / 8;
   localparam int          LIM = 8;

   logic            clk = 1'b0;
   logic            reset_i;
   logic            cpu_sel_i, cpu_wr_en_i;
   logic [MW-1:0]   cpu_wr_mask_i;
   logic [AW-1:0]   cpu_address_in_i;
   logic [DW-1:0]   cpu_data_in_i, cpu_data_out_o;
   logic            cpu_ack_o;
   logic            disp_req_i;
   logic [AW-1:0]   disp_addr_i;
   logic            disp_gnt_o, disp_rvalid_o;
   logic [DW-1:0]   disp_rdata_o;
   logic [AW-1:0]   mem_addr_o;
   logic            mem_wr_en_o;
   logic [MW-1:0]   mem_wr_mask_o;
   logic [DW-1:0]   mem_data_o, mem_data_i;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset_i(reset_i),
      .cpu_sel_i(cpu_sel_i), .cpu_wr_en_i(cpu_wr_en_i), .cpu_wr_mask_i(cpu_wr_mask_i),
      .cpu_address_in_i(cpu_address_in_i), .cpu_data_in_i(cpu_data_in_i),
      .cpu_data_out_o(cpu_data_out_o), .cpu_ack_o(cpu_ack_o),
      .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
      .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
      .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o), .mem_wr_mask_o(mem_wr_mask_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
   );

   always #5 clk = ~clk;

   // Synchronous-read BRAM fixture with byte write enables.
   logic [DW-1:0] vram [0:2**AW-1];
   logic [DW-1:0] sh   [0:2**AW-1];
   logic [DW-1:0] mem_q;
   assign mem_data_i = mem_q;

   always @(posedge clk) begin
      if (mem_wr_en_o) begin
         for (int b = 0; b < MW; b++) begin
            if (mem_wr_mask_o[b]) vram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
         end
      end
      mem_q <= vram[mem_addr_o];
   end

   // Behavioural model state: cycles until the CPU port can be served again,
   // how long an eligible CPU request has waited, and expected responses.
   int            busy, waited, last_g;
   bit            exp_ack, exp_ack_wr, exp_rvalid;
   logic [AW-1:0] exp_ack_addr, exp_rd_addr;
   int            checks = 0;
   int            errors = 0;

   function automatic logic [DW-1:0] init_word(input int i);
      return DW'(i * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; waited = 0; last_g = 0;
      exp_ack = 1'b0; exp_ack_wr = 1'b0; exp_rvalid = 1'b0;
   endtask

   // One clock cycle: check at the falling edge, advance the model at the rising edge.
   task automatic step();
      bit elig, frc;
      int g;
      @(negedge clk);
      elig = (busy == 0) && cpu_sel_i;
      frc  = elig && (waited >= LIM);
      g    = (disp_req_i && !frc) ? 1 : (elig ? 2 : 0);
      chk("disp_gnt", 64'(disp_gnt_o), 64'(g == 1));
      chk("mem_wr_en", 64'(mem_wr_en_o), 64'(g == 2 && cpu_wr_en_i));
      chk("mem_addr", 64'(mem_addr_o), 64'((g == 2) ? cpu_address_in_i : disp_addr_i));
      if (g == 2 && cpu_wr_en_i) begin
         chk("mem_mask", 64'(mem_wr_mask_o), 64'(cpu_wr_mask_i));
         chk("mem_wdata", 64'(mem_data_o), 64'(cpu_data_in_i));
      end
      chk("cpu_ack", 64'(cpu_ack_o), 64'(exp_ack));
      chk("disp_rvalid", 64'(disp_rvalid_o), 64'(exp_rvalid));
      if (exp_rvalid) chk("disp_rdata", 64'(disp_rdata_o), 64'(sh[exp_rd_addr]));
      if (exp_ack && !exp_ack_wr) chk("cpu_rdata", 64'(cpu_data_out_o), 64'(sh[exp_ack_addr]));
      last_g = g;
      @(posedge clk);
      exp_ack      = (g == 2);
      exp_ack_wr   = cpu_wr_en_i;
      exp_ack_addr = cpu_address_in_i;
      exp_rvalid   = (g == 1);
      exp_rd_addr  = disp_addr_i;
      if (g == 2 && cpu_wr_en_i) begin
         for (int b = 0; b < MW; b++) begin
            if (cpu_wr_mask_i[b]) sh[cpu_address_in_i][8*b +: 8] = cpu_data_in_i[8*b +: 8];
         end
      end
      waited = (g == 2) ? 0 : (elig ? ((waited + 1 > LIM) ? LIM : waited + 1) : 0);
      busy   = (g == 2) ? 2 : ((busy > 0) ? busy - 1 : 0);
      #1;
   endtask

   task automatic set_cpu(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
      cpu_sel_i = 1'b1; cpu_wr_en_i = wr; cpu_address_in_i = a;
      cpu_data_in_i = d; cpu_wr_mask_i = m;
   endtask

   // Full CPU transaction with a bounded wait for the grant.
   task automatic cpu_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
      set_cpu(wr, a, d, m);
      for (int i = 0; i < 30; i++) begin
         step();
         if (last_g == 2) break;
      end
      chk("cpu_txn_granted", 64'(last_g == 2), 64'(1));
      cpu_sel_i = 1'b0;
      step();
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_idle, first_ack;
      logic [DW-1:0] t1_exp;
      for (int i = 0; i < 2**AW; i++) begin
         vram[i] = init_word(i);
         sh[i]   = init_word(i);
      end
      model_reset();

      // Reset values, with both requesters active to prove grants are masked.
      reset_i = 1'b1;
      disp_req_i = 1'b1; disp_addr_i = '0;
      set_cpu(1'b1, AW'(5), 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      chk("rst_ack", 64'(cpu_ack_o), 64'(0));
      chk("rst_rvalid", 64'(disp_rvalid_o), 64'(0));
      chk("rst_rdata", 64'(disp_rdata_o), 64'(0));
      chk("rst_cpu_dout", 64'(cpu_data_out_o), 64'(0));
      chk("rst_gnt", 64'(disp_gnt_o), 64'(0));
      chk("rst_wr_en", 64'(mem_wr_en_o), 64'(0));
      @(posedge clk); #1;
      reset_i = 1'b0; disp_req_i = 1'b0; cpu_sel_i = 1'b0;
      model_reset();
      step();

      // CPU masked write with idle display, then read back.
      set_cpu(1'b1, AW'(16'h0010), 32'hAABBCCDD, 4'b0101);
      #1;
      chk("t1_wr_en", 64'(mem_wr_en_o), 64'(1));
      chk("t1_mask", 64'(mem_wr_mask_o), 64'(4'b0101));
      step();
      cpu_sel_i = 1'b0;
      #1 chk("t1_ack", 64'(cpu_ack_o), 64'(1));
      step();
      step();
      set_cpu(1'b0, AW'(16'h0010), 32'h0, 4'h0);
      step();
      cpu_sel_i = 1'b0;
      t1_exp = (init_word(16) & 32'hFF00FF00) | (32'hAABBCCDD & 32'h00FF00FF);
      #1 chk("t1_readback", 64'(cpu_data_out_o), 64'(t1_exp));
      step();
      step();

      // Display streaming, addresses 0..5.
      disp_req_i = 1'b1;
      for (int a = 0; a < 6; a++) begin
         disp_addr_i = AW'(a);
         #1 chk("t2_gnt", 64'(disp_gnt_o), 64'(1));
         step();
      end
      disp_req_i = 1'b0;
      step();

      // Starvation: CPU read of 0x0100 against continuous display requests.
      disp_req_i = 1'b1; disp_addr_i = AW'(16'h0200);
      set_cpu(1'b0, AW'(16'h0100), 32'h0, 4'h0);
      first_idle = 0; first_ack = 0;
      for (int i = 1; i <= 14; i++) begin
         #1;
         if (!disp_gnt_o && first_idle == 0) first_idle = i;
         if (cpu_ack_o && first_ack == 0) first_ack = i;
         step();
         if (last_g == 2) cpu_sel_i = 1'b0;
      end
      chk("t3_cpu_win_cycle", 64'(first_idle), 64'(9));
      chk("t3_ack_cycle", 64'(first_ack), 64'(10));
      disp_req_i = 1'b0;
      step();

      // Simultaneous request: display first, CPU next, no grant during RECOVER.
      disp_req_i = 1'b1; disp_addr_i = AW'(7);
      set_cpu(1'b0, AW'(16'h0020), 32'h0, 4'h0);
      #1 chk("t4_disp_first", 64'(disp_gnt_o), 64'(1));
      step();
      disp_req_i = 1'b0;
      #1 chk("t4_cpu_next", 64'(mem_addr_o), 64'(16'h0020));
      step();
      step();
      #1 chk("t4_recover_addr", 64'(mem_addr_o), 64'(7));
      step();
      step();
      cpu_sel_i = 1'b0;
      step(); step(); step();

      // Asynchronous reset in the ACK cycle of a CPU read.
      set_cpu(1'b0, AW'(16'h0030), 32'h0, 4'h0);
      step();
      #1 chk("t5_ack_before", 64'(cpu_ack_o), 64'(1));
      set_cpu(1'b1, AW'(16'h0031), 32'h12345678, 4'hF);
      #1 reset_i = 1'b1;
      #1;
      chk("t5_ack_cleared", 64'(cpu_ack_o), 64'(0));
      chk("t5_no_write", 64'(mem_wr_en_o), 64'(0));
      @(posedge clk); #1;
      reset_i = 1'b0; cpu_sel_i = 1'b0;
      model_reset();
      step();

      // Reset asserted in the same cycle as a CPU write grant blocks the write.
      set_cpu(1'b1, AW'(16'h0032), 32'hCAFEF00D, 4'hF);
      #2 reset_i = 1'b1;
      #1 chk("t5_same_cycle_block", 64'(mem_wr_en_o), 64'(0));
      @(posedge clk); #1;
      reset_i = 1'b0; cpu_sel_i = 1'b0;
      model_reset();
      step();
      cpu_txn(1'b0, AW'(16'h0031), 32'h0, 4'h0);
      cpu_txn(1'b0, AW'(16'h0032), 32'h0, 4'h0);
      cpu_txn(1'b1, AW'(16'h0033), 32'h0BADF00D, 4'b1001);
      cpu_txn(1'b0, AW'(16'h0033), 32'h0, 4'h0);

      // Randomized mixed traffic in a small address window.
      for (int c = 0; c < 600; c++) begin
         if (cpu_sel_i) begin
            if (last_g == 2) cpu_sel_i = ($urandom % 3 == 0);
            else if ($urandom % 16 == 0) cpu_sel_i = 1'b0;
         end else if ($urandom % 3 == 0) begin
            set_cpu(1'($urandom), AW'($urandom_range(0, 63)), $urandom, MW'($urandom));
         end
         if (last_g == 1 || !disp_req_i) begin
            disp_req_i  = ($urandom % 4 != 0);
            disp_addr_i = AW'($urandom_range(0, 63));
         end
         step();
      end
      cpu_sel_i = 1'b0; disp_req_i = 1'b0;
      step(); step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
